// File: rtl/pe_result_packer_if.sv
// Element stream from the PE plus the word-write port to the vector register file.
// The packer side uses the master modport and the PE/register-file side uses the slave modport.
interface pe_result_packer_if;
    logic        elem_valid;
    logic        elem_ready;
    logic [31:0] elem_data;
    logic        elem_mask;
    logic        wr_en;
    logic        wr_ready;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    modport master (
        input  elem_valid, elem_data, elem_mask, wr_ready,
        output elem_ready, wr_en, wr_addr, wr_data, wr_be
    );

    modport slave (
        output elem_valid, elem_data, elem_mask, wr_ready,
        input  elem_ready, wr_en, wr_addr, wr_data, wr_be
    );
endinterface

// File: rtl/pe_result_packer.sv
// Writeback packer: truncates PE results to the element width, packs them into 32-bit
// vector-register words with byte enables and issues one word write per valid/ready handshake.
module pe_result_packer (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               start,
    input  logic [4:0]         vd,
    input  logic [1:0]         vsew,
    input  logic [4:0]         vl,
    output logic               busy,
    output logic               done,
    pe_result_packer_if.master bus
);
    localparam int         VLEN       = 128;
    localparam logic [4:0] MAX_ELEMS8 = 5'(VLEN / 8);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_FIN} state_e;

    state_e      state_q, state_d;
    logic [4:0]  vd_q;
    logic [1:0]  vsew_q;
    logic [4:0]  vl_eff_q;
    logic [4:0]  idx_q;
    logic [31:0] buf_data_q;
    logic [3:0]  buf_be_q;
    logic        wr_en_q;
    logic [6:0]  wr_addr_q;
    logic [31:0] wr_data_q;
    logic [3:0]  wr_be_q;

    logic [1:0]  vsew_eff;
    logic [4:0]  max_elems, vl_cap;
    logic        lane_last, last_elem, completing;
    logic        accept, load, wr_hs;
    logic [1:0]  word_idx;
    logic [3:0]  lane_mask;
    logic [31:0] data_rep, merged_data;
    logic [3:0]  merged_be;

    // Instruction parameters as they will be latched on start.
    always_comb begin
        vsew_eff  = (vsew == 2'd3) ? 2'd2 : vsew;
        max_elems = MAX_ELEMS8 >> vsew_eff;
        vl_cap    = (vl < max_elems) ? vl : max_elems;
    end

    // Placement of the current element, decoded from the registered index only so that
    // elem_ready never depends combinationally on elem_valid or wr_ready.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a
        // missed branch holds its old value and synthesis infers a latch.
        lane_last = 1'b1;
        word_idx  = idx_q[1:0];
        lane_mask = 4'hF;
        data_rep  = bus.elem_data;
        case (vsew_q)
            2'd0: begin
                lane_last = &idx_q[1:0];
                word_idx  = idx_q[3:2];
                lane_mask = 4'b0001 << idx_q[1:0];
                data_rep  = {4{bus.elem_data[7:0]}};
            end
            2'd1: begin
                lane_last = idx_q[0];
                word_idx  = idx_q[2:1];
                lane_mask = 4'b0011 << {idx_q[0], 1'b0};
                data_rep  = {2{bus.elem_data[15:0]}};
            end
            default: ;
        endcase
        last_elem  = (idx_q == vl_eff_q - 5'd1);
        completing = lane_last || last_elem;
    end

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            merged_data[8*b +: 8] = lane_mask[b] ? data_rep[8*b +: 8] : buf_data_q[8*b +: 8];
        end
        merged_be = buf_be_q | (bus.elem_mask ? lane_mask : 4'b0000);
        accept    = bus.elem_valid && bus.elem_ready;
        load      = accept && completing;
        wr_hs     = wr_en_q && bus.wr_ready;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples
        // the pre-edge values, independent of statement order.
        if (!n_reset) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = (vl_cap == 5'd0) ? S_FIN : S_COLLECT;
            S_COLLECT: if (accept && last_elem) state_d = S_DRAIN;
            S_DRAIN:   if (wr_hs) state_d = S_FIN;
            S_FIN:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.elem_ready = (state_q == S_COLLECT) && !(wr_en_q && completing);
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_FIN);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            vd_q       <= '0;
            vsew_q     <= '0;
            vl_eff_q   <= '0;
            idx_q      <= '0;
            buf_data_q <= '0;
            buf_be_q   <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_be_q    <= '0;
        end else begin
            if (state_q == S_IDLE && start) begin
                vd_q       <= vd;
                vsew_q     <= vsew_eff;
                vl_eff_q   <= vl_cap;
                idx_q      <= '0;
                buf_data_q <= '0;
                buf_be_q   <= '0;
            end
            if (accept) begin
                idx_q <= idx_q + 5'd1;
                if (completing) begin
                    buf_data_q <= '0;
                    buf_be_q   <= '0;
                end else begin
                    buf_data_q <= merged_data;
                    buf_be_q   <= merged_be;
                end
            end
            // A freshly loaded word overrides the drop that a handshake would cause.
            if (load) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= {vd_q, word_idx};
                wr_data_q <= merged_data;
                wr_be_q   <= merged_be;
            end else if (wr_hs) begin
                wr_en_q <= 1'b0;
            end
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.wr_be   = wr_be_q;
endmodule
